pixmem_pingpong: RTL and testbench

//   Parametrised multi-bank frame-buffer memory for the image pipeline. It replaces the fixed
//   two-array 320x240 combinational pixel store with a clocked, banked double/rotating buffer.
//   The processing stage writes a frame into the back bank while the display/readout stage

---
 rtl/pixmem_pkg.sv | 14 +
 rtl/pixmem_bank.sv | 29 ++
 rtl/pixmem_pingpong.sv | 165 ++++++++++++++++
 tb/tb_pixmem_pingpong.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixmem_pkg.sv
// Shared types and helpers for the banked pixel frame-buffer.
package pixmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Successor bank index with wrap at n.
    function automatic int unsigned next_bank(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/pixmem_bank.sv
// One frame bank: synchronous write, registered synchronous read, DEPTH x PIX_W.
module pixmem_bank
    import pixmem_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixmem_pingpong.sv
// Banked ping-pong / rotating frame buffer with post-reset zero clear and frame-done swap.
// Optional sticky out-of-range error output enabled by defining PIXMEM_OOB_ERR_EN.
module pixmem_pingpong
    import pixmem_pkg::*;
#(
    parameter int  PIX_W     = 8,
    parameter int  IMG_W     = 320,
    parameter int  IMG_H     = 240,
    parameter int  NUM_BANKS = 2,
    localparam int DEPTH     = IMG_W * IMG_H,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              wr_frame_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [BANK_W-1:0] front_bank,
    output logic              swap_pending,
    output logic              busy
`ifdef PIXMEM_OOB_ERR_EN
    ,
    output logic              oob_err
`endif
);

    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg;
    logic [BANK_W-1:0] clr_bank_reg;
    logic [BANK_W-1:0] front_bank_reg;
    logic              swap_pending_reg;
    logic              rd_valid_reg;
    logic              rd_oob_reg;
    logic [BANK_W-1:0] rd_bank_reg;

    logic              running;
    logic              clear_last;
    logic              wr_in_range, rd_in_range;
    logic              wr_ok, rd_ok;
    logic [BANK_W-1:0] back_bank;
    logic [ADDR_W-1:0] bank_waddr;
    logic [PIX_W-1:0]  bank_wdata;
    logic [NUM_BANKS-1:0] bank_we, bank_re;
    logic [PIX_W-1:0]  bank_rdata [NUM_BANKS];

    assign running     = (state_reg == RUN);
    assign clear_last  = (clr_addr_reg == ADDR_W'(DEPTH - 1)) &&
                         (clr_bank_reg == BANK_W'(NUM_BANKS - 1));
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_CMP);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_CMP);
    assign wr_ok       = running && wr_en && wr_in_range;
    assign rd_ok       = running && rd_en && rd_in_range;
    assign back_bank   = BANK_W'(next_bank(int'(front_bank_reg), NUM_BANKS));
    assign bank_waddr  = running ? wr_addr : clr_addr_reg;
    assign bank_wdata  = running ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR:   if (clear_last) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    // Bank-major sweep: address counter rolls into the bank counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_reg <= '0;
            clr_bank_reg <= '0;
        end else if (!running) begin
            if (clr_addr_reg == ADDR_W'(DEPTH - 1)) begin
                clr_addr_reg <= '0;
                clr_bank_reg <= clr_bank_reg + 1'b1;
            end else begin
                clr_addr_reg <= clr_addr_reg + 1'b1;
            end
        end
    end

    // A pending swap waits for a cycle with no read so a read never straddles banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_bank_reg   <= '0;
            swap_pending_reg <= 1'b0;
        end else if (running) begin
            if (swap_pending_reg && !rd_en) begin
                front_bank_reg   <= back_bank;
                swap_pending_reg <= 1'b0;
            end else if (wr_frame_done) begin
                swap_pending_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_oob_reg   <= 1'b0;
            rd_bank_reg  <= '0;
        end else begin
            rd_valid_reg <= running && rd_en;
            rd_oob_reg   <= !rd_in_range;
            rd_bank_reg  <= front_bank_reg;
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        assign bank_we[gi] = running ? (wr_ok && (back_bank == BANK_W'(gi)))
                                     : (clr_bank_reg == BANK_W'(gi));
        assign bank_re[gi] = rd_ok && (front_bank_reg == BANK_W'(gi));

        pixmem_bank #(
            .PIX_W  (PIX_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[gi]),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (bank_re[gi]),
            .raddr (rd_addr),
            .rdata (bank_rdata[gi])
        );
    end

    assign rd_data      = (rd_valid_reg && !rd_oob_reg) ? bank_rdata[rd_bank_reg] : '0;
    assign rd_valid     = rd_valid_reg;
    assign front_bank   = front_bank_reg;
    assign swap_pending = swap_pending_reg;
    assign busy         = !running;

`ifdef PIXMEM_OOB_ERR_EN
    logic oob_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err_reg <= 1'b0;
        end else if (running && ((rd_en && !rd_in_range) || (wr_en && !wr_in_range))) begin
            oob_err_reg <= 1'b1;
        end
    end

    assign oob_err = oob_err_reg;
`endif

endmodule

// File: tb/tb_pixmem_pingpong.sv
// Bench: two instances (2 banks 4x2, 3 banks 3x2) share one stimulus stream and are
// compared every cycle against an array-based frame-buffer model.
module tb_pixmem_pingpong;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_en, wr_frame_done, rd_en;
    logic [2:0] wr_addr, rd_addr;
    logic [7:0] wr_data;

    logic [7:0] rd_data2, rd_data3;
    logic       rd_valid2, rd_valid3;
    logic [0:0] front2;
    logic [1:0] front3;
    logic       pend2, pend3, busy2, busy3;
`ifdef PIXMEM_OOB_ERR_EN
    logic       oob2, oob3;
`endif

    pixmem_pingpong #(.PIX_W(8), .IMG_W(4), .IMG_H(2), .NUM_BANKS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_frame_done(wr_frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .front_bank(front2),
        .swap_pending(pend2), .busy(busy2)
`ifdef PIXMEM_OOB_ERR_EN
        , .oob_err(oob2)
`endif
    );

    pixmem_pingpong #(.PIX_W(8), .IMG_W(3), .IMG_H(2), .NUM_BANKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_frame_done(wr_frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .front_bank(front3),
        .swap_pending(pend3), .busy(busy3)
`ifdef PIXMEM_OOB_ERR_EN
        , .oob_err(oob3)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: per-instance frame contents and buffer state.
    int         depth [2] = '{8, 6};
    int         nb    [2] = '{2, 3};
    logic [7:0] mem   [2][3][8];
    int         m_front [2];
    int         m_clr   [2];
    bit         m_pend  [2];
    bit         m_valid [2];
    bit         m_oob   [2];
    logic [7:0] m_data  [2];

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            m_front[i] = 0;
            m_pend[i]  = 1'b0;
            m_clr[i]   = nb[i] * depth[i];
            m_valid[i] = 1'b0;
            m_data[i]  = 8'h00;
            m_oob[i]   = 1'b0;
            for (int b = 0; b < 3; b++)
                for (int a = 0; a < 8; a++)
                    mem[i][b][a] = 8'h00;
        end
    endtask

    task automatic mdl_edge();
        for (int i = 0; i < 2; i++) begin
            if (m_clr[i] > 0) begin
                m_clr[i]--;
                m_valid[i] = 1'b0;
                m_data[i]  = 8'h00;
            end else begin
                m_valid[i] = rd_en;
                m_data[i]  = (rd_en && int'(rd_addr) < depth[i]) ? mem[i][m_front[i]][rd_addr] : 8'h00;
                if (wr_en && int'(wr_addr) < depth[i])
                    mem[i][(m_front[i] + 1) % nb[i]][wr_addr] = wr_data;
                if ((rd_en && int'(rd_addr) >= depth[i]) || (wr_en && int'(wr_addr) >= depth[i]))
                    m_oob[i] = 1'b1;
                if (m_pend[i] && !rd_en) begin
                    m_front[i] = (m_front[i] + 1) % nb[i];
                    m_pend[i]  = 1'b0;
                end else if (wr_frame_done) begin
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy%0d", i), (i == 0) ? busy2 : busy3, (m_clr[i] > 0));
            chk($sformatf("rd_valid%0d", i), (i == 0) ? rd_valid2 : rd_valid3, m_valid[i]);
            if (m_valid[i])
                chk($sformatf("rd_data%0d", i), (i == 0) ? rd_data2 : rd_data3, m_data[i]);
            chk($sformatf("front%0d", i), (i == 0) ? 32'(front2) : 32'(front3), m_front[i]);
            chk($sformatf("pend%0d", i), (i == 0) ? pend2 : pend3, m_pend[i]);
`ifdef PIXMEM_OOB_ERR_EN
            chk($sformatf("oob%0d", i), (i == 0) ? oob2 : oob3, m_oob[i]);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) mdl_edge();
        else       mdl_reset();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_frame_done = 1'b0; rd_en = 1'b0; rd_addr = '0;
    endtask

    // Run clear to completion, returning how many cycles dut2 reported busy.
    task automatic wait_clear(output int n2);
        int n;
        n = 0;
        n2 = 0;
        while ((busy2 || busy3) && n < 100) begin
            step();
            n++;
            if (n2 == 0 && !busy2) n2 = n;
        end
        chk("clear_timeout", n < 100, 1);
    endtask

    initial begin
        int  n2;
        int  seq [3];

        idle_inputs();
        rst_n = 1'b0;
        #12;
        mdl_reset();
        check_all();

        // 1: clear sweep ignores reads, then first read returns zero.
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_en = 1'b1; rd_addr = 3'd2;
        wait_clear(n2);
        chk("clear_len", n2, 16);
        rd_addr = 3'd3;
        step();
        chk("t1_rd_valid", rd_valid2, 1);
        chk("t1_rd_data", rd_data2, 0);

        // 2: write back bank, invisible until swap.
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hA5;
        step();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 3'd5;
        step();
        chk("t2_pre_swap", rd_data2, 8'h00);
        idle_inputs();
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        step();
        chk("t2_front", front2, 1);
        rd_en = 1'b1; rd_addr = 3'd5;
        step();
        chk("t2_post_swap", rd_data2, 8'hA5);

        // 3: swap held off while reads continue.
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        repeat (3) step();
        chk("t3_pend_held", pend2, 1);
        chk("t3_front_held", front2, 1);
        rd_en = 1'b0;
        step();
        chk("t3_front_swap", front2, 0);
        chk("t3_pend_clr", pend2, 0);

        // 4: repeated frame-done while pending yields one swap; 3-bank rotation.
        rd_en = 1'b1;
        wr_frame_done = 1'b1; step();
        wr_frame_done = 1'b0; step();
        wr_frame_done = 1'b1; step();
        wr_frame_done = 1'b0; step();
        rd_en = 1'b0;
        step();
        step();
        chk("t4_one_swap", front2, 1);
        for (int k = 0; k < 3; k++) begin
            wr_frame_done = 1'b1; step();
            wr_frame_done = 1'b0; step();
            seq[k] = int'(front3);
        end
        chk("t4_rot0", seq[0], 1);
        chk("t4_rot1", seq[1], 2);
        chk("t4_rot2", seq[2], 0);

        // 5: out-of-range write/read on the 6-word instance.
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hFF;
        rd_en = 1'b1; rd_addr = 3'd7;
        step();
        chk("t5_oob_valid", rd_valid3, 1);
        chk("t5_oob_data", rd_data3, 0);
        idle_inputs();
        step();

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            wr_en         = 1'($urandom_range(0, 1));
            wr_addr       = 3'($urandom_range(0, 7));
            wr_data       = 8'($urandom);
            wr_frame_done = ($urandom_range(0, 7) == 0);
            rd_en         = 1'($urandom_range(0, 1));
            rd_addr       = 3'($urandom_range(0, 7));
            step();
        end
        idle_inputs();

        // 6: reset in the middle of the clear sweep restarts it from word 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        mdl_reset();
        check_all();
        step();
        rst_n = 1'b1;
        wait_clear(n2);
        chk("t6_clear_len", n2, 16);
        chk("t6_front", front2, 0);
        for (int pass = 0; pass < 2; pass++) begin
            rd_en = 1'b1;
            for (int a = 0; a < 8; a++) begin
                rd_addr = 3'(a);
                step();
                chk("t6_zero", rd_data2, 0);
            end
            rd_en = 1'b0;
            wr_frame_done = 1'b1; step();
            wr_frame_done = 1'b0; step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
